aes_key_expand_seq: RTL
=======================

Name: aes_key_expand_seq

Overview:
Iterative, parametrised AES key-schedule engine supporting AES-128/192/256 through NK. It generates one 32-bit schedule word per clock using a single shared 4-byte S-box, and stores the full schedule internally. Round keys are served to the cipher datapath through an indexed, registered read port. It replaces the flat combinational expansion so that the cipher core can run on a clocked, low-area path.

Parameters:
NK, 4, key length in 32-bit words; legal values 4, 6, 8 (elaboration error otherwise).
NR, NK+6, number of rounds; derived localparam, not overridable.
NW, 4*(NR+1), total schedule words (44/52/60).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request to expand `key`; sampled only in IDLE or DONE.
key  input  256  cipher key, bit 0 = MSB of first key byte; only bits [0:32*NK-1] used, rest ignored.
busy  output  1  high while loading or expanding.
done  output  1  one-cycle pulse when the last word is written.
keys_valid  output  1  level; high from done until next accepted start or reset.
rk_idx  input  4  round-key index 0..NR.
rk  output  128  registered round key {w[4*rk_idx], …, w[4*rk_idx+3]}, 1-cycle latency.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, keys_valid=0, rk=0; word index, rcon and schedule storage cleared to 0.
- State machine:
  - IDLE: start=1 -> LOAD.
  - LOAD (1 cycle): w[0..NK-1] <= key words; i <= NK; rcon <= 8'h01 -> EXPAND.
  - EXPAND: one word per cycle, w[i] <= w[i-NK] ^ temp, where temp is derived from w[i-1]:
    - i%NK==0: SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; rcon <= xtime(rcon), i.e. (rcon<<1) ^ (msb ? 8'h1b : 0).
    - NK==8 and i%NK==4: SubWord(w[i-1]).
    - otherwise: w[i-1].
    - i increments each cycle; when i==NW-1 is written -> DONE.
  - DONE: done=1 for the entry cycle only; keys_valid=1. start=1 -> LOAD, with keys_valid cleared in the same cycle.
- Latency from start sampled to done: 1 (LOAD) + (NW-NK) cycles, i.e. 41 / 47 / 53 for NK=4/6/8.
- busy=1 in LOAD and EXPAND only.
- start in LOAD/EXPAND is ignored; no queueing, and the current expansion is unaffected.
- key must be stable only in the cycle start is sampled; it is captured in LOAD from a register stage taken at start.
- rk read:
  - Registered every cycle regardless of keys_valid; returns the current storage contents.
  - rk_idx > NR returns all zeros.
  - Reading while busy returns partially-written data; the consumer must gate reads on keys_valid.
- rk_idx change takes effect on rk the next cycle. Reading an index concurrently being written returns the pre-write value.
- rst_n asserted mid-expansion: immediate abort to the reset values. A fresh start is required afterwards.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. Consumption count is 10 / 8 / 7 for NK=4/6/8, so no overflow past 36.
- S-box: a single 256-entry combinational byte map instantiated 4× (one SubWord path), shared between both SubWord cases.

Test Plan:
- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> done exactly 41 cycles later. rk_idx=1 gives a0fafe1788542cb123a339392a6c7605; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 47 cycles. w[6]=fe0c91f7; rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 53 cycles. w[8]=9ba35411; w[12]=a8b09c1a (i%8==4 path); rk_idx=14 gives fe4890d1e6188d0b046df344706c631e.
- start re-pulsed at cycle 10 of an expansion -> ignored; done timing and schedule identical to the first scenario. A second start in DONE with a new key -> keys_valid drops the next cycle and a new done arrives 41 cycles later.
- rst_n pulsed low at cycle 20 of an expansion -> busy/done/keys_valid/rk go to 0 asynchronously; no done follows. A subsequent start reproduces correct vectors.
- rk_idx=15 with keys_valid=1 -> rk=0 the next cycle. Toggling rk_idx 0→10→0 on consecutive cycles -> rk follows with exactly 1-cycle lag.

Source files
------------

// File: rtl/aes_key_expand_seq.sv
// Iterative AES key-schedule engine (AES-128/192/256 selected by NK).
// One schedule word is produced per clock through a shared 4-byte S-box; round keys come out of a registered read port.

module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the byte offset of entry a is 255-a = ~a.
  logic [10:0] sel;
  assign sel = {~a_i, 3'b000};
  assign s_o = SBOX[sel +: 8];

endmodule

module aes_key_expand_seq #(
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [0:255] key,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk
);

  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam int AW = $clog2(NW);
  localparam logic [AW-1:0] NK_W   = AW'(NK);
  localparam logic [AW-1:0] LAST_W = AW'(NW - 1);
  localparam logic [2:0]    KC_END = 3'(NK - 1);
  localparam logic [3:0]    NR_W   = 4'(NR);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_nk_check
    $error("aes_key_expand_seq: NK must be 4, 6 or 8");
  end

  if (NK < 8) begin : g_unused_key
    logic unused_key;
    assign unused_key = ^key[32*NK:255];
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

  state_t              state_q;
  logic                busy_q, done_q, kv_q;
  logic [AW-1:0]       i_q;
  logic [2:0]          kc_q;
  logic [7:0]          rcon_q;
  logic [32*NK-1:0]    key_q;
  logic [31:0]         w_q [NW];
  logic [127:0]        rk_q;

  logic [31:0] w_prev, w_old, rot_w, sub_in, sub_w, temp_w, w_new_d;
  logic [5:0]  rd_base;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Word i depends on w[i-1] (through temp) and w[i-NK].
  assign w_prev = w_q[i_q - AW'(1)];
  assign w_old  = w_q[i_q - NK_W];
  assign rot_w  = {w_prev[23:0], w_prev[31:24]};
  assign sub_in = (kc_q == 3'd0) ? rot_w : w_prev;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a_i (sub_in[8*b +: 8]),
      .s_o (sub_w[8*b +: 8])
    );
  end

  always_comb begin
    temp_w = w_prev;
    if (kc_q == 3'd0)
      temp_w = sub_w ^ {rcon_q, 24'h000000};
    else if (NK == 8 && kc_q == 3'd4)
      temp_w = sub_w;
    w_new_d = w_old ^ temp_w;
  end

  // The key is only guaranteed stable in the start cycle, so it is latched then.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE || state_q == S_DONE) && start)
      key_q <= key[0 +: 32*NK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      kv_q    <= 1'b0;
      i_q     <= '0;
      kc_q    <= '0;
      rcon_q  <= '0;
      for (int j = 0; j < NW; j++) w_q[j] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            kv_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          for (int j = 0; j < NK; j++) w_q[j] <= key_q[32*(NK-1-j) +: 32];
          i_q     <= NK_W;
          kc_q    <= 3'd0;
          rcon_q  <= 8'h01;
          state_q <= S_EXPAND;
        end
        S_EXPAND: begin
          w_q[i_q] <= w_new_d;
          i_q      <= i_q + AW'(1);
          kc_q     <= (kc_q == KC_END) ? 3'd0 : kc_q + 3'd1;
          if (kc_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (i_q == LAST_W) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            kv_q    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Registered read port: reflects storage as of the previous cycle.
  assign rd_base = {rk_idx, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rk_q <= '0;
    else if (rk_idx <= NR_W)
      rk_q <= {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    else
      rk_q <= '0;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = kv_q;
  assign rk         = rk_q;

endmodule
